// File: rtl/posit_stream_checker.sv
// Streaming checker for a posit adder: golden results go into a FIFO, adder results pop and compare.
// Optional max_diff tracking is enabled by defining POSIT_CHECKER_MAXDIFF_EN.
module posit_stream_checker #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TOL   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     exp_valid,
    input  logic [N-1:0]             exp_data,
    input  logic                     dut_valid,
    input  logic [N-1:0]             dut_data,
    output logic                     cmp_valid,
    output logic                     mismatch,
    output logic [N-1:0]             diff,
    output logic [31:0]              err_count,
    output logic [31:0]              cmp_count,
    output logic [N-1:0]             max_diff,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     busy,
    output logic                     finished
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [N-1:0]  head;
    logic          clear, push_req, pop_req, push, pop, empty, full;
    logic [N-1:0]  diff_c;
    logic          mis_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        finished = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (!start) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (start) begin
                    state_nx = S_RUN;
                end else if (empty) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                finished = 1'b1;
                if (start) state_nx = S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted then
    always_comb begin
        clear    = ((state == S_IDLE) || (state == S_DONE)) && start;
        push_req = (state == S_RUN) && exp_valid;
        pop_req  = ((state == S_RUN) || (state == S_DRAIN)) && dut_valid;
        empty    = (level == '0);
        full     = (level == FULL_LEVEL);
        pop      = pop_req && !empty;
        push     = push_req && (!full || pop);
        head     = mem[rd_ptr];
    end

    always_comb begin
        diff_c = '0;
        mis_c  = 1'b0;
        if ((head == NAR) || (dut_data == NAR)) begin
            diff_c = head ^ dut_data;
            mis_c  = (head != dut_data);
        end else begin
            diff_c = (head >= dut_data) ? (head - dut_data) : (dut_data - head);
            mis_c  = (diff_c > N'(TOL));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= exp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_req && full && !pop) overflow  <= 1'b1;
            if (pop_req && empty)         underflow <= 1'b1;
        end
    end

    // Counters advance on the pop edge so they line up with the registered cmp_valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid <= 1'b0;
            mismatch  <= 1'b0;
            diff      <= '0;
            cmp_count <= '0;
            err_count <= '0;
        end else begin
            cmp_valid <= pop;
            if (pop) begin
                diff     <= diff_c;
                mismatch <= mis_c;
            end
            if (clear) begin
                cmp_count <= '0;
                err_count <= '0;
            end else if (pop) begin
                if (cmp_count != '1)          cmp_count <= cmp_count + 32'd1;
                if (mis_c && (err_count != '1)) err_count <= err_count + 32'd1;
            end
        end
    end

`ifdef POSIT_CHECKER_MAXDIFF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_diff <= '0;
        end else if (clear) begin
            max_diff <= '0;
        end else if (pop && (diff_c > max_diff)) begin
            max_diff <= diff_c;
        end
    end
`else
    assign max_diff = '0;
`endif

endmodule

// File: tb/tb_posit_stream_checker.sv
// Self-checking bench: queue-based model of the checker, two DUTs (TOL=0 and TOL=2) on shared stimulus.
module tb_posit_stream_checker;

    localparam logic [31:0] NAR = 32'h8000_0000;
`ifdef POSIT_CHECKER_MAXDIFF_EN
    localparam bit MAXEN = 1'b1;
`else
    localparam bit MAXEN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, ev, dv;
    logic [31:0] ed, dd;

    logic        a_cmp_valid, a_mismatch, a_overflow, a_underflow, a_busy, a_finished;
    logic [31:0] a_diff, a_err_count, a_cmp_count, a_max_diff;
    logic [4:0]  a_level;
    logic        b_cmp_valid, b_mismatch, b_overflow, b_underflow, b_busy, b_finished;
    logic [31:0] b_diff, b_err_count, b_cmp_count, b_max_diff;
    logic [4:0]  b_level;

    posit_stream_checker #(.N(32), .DEPTH(16), .TOL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .exp_valid(ev), .exp_data(ed), .dut_valid(dv), .dut_data(dd),
        .cmp_valid(a_cmp_valid), .mismatch(a_mismatch), .diff(a_diff),
        .err_count(a_err_count), .cmp_count(a_cmp_count), .max_diff(a_max_diff),
        .level(a_level), .overflow(a_overflow), .underflow(a_underflow),
        .busy(a_busy), .finished(a_finished)
    );

    posit_stream_checker #(.N(32), .DEPTH(16), .TOL(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .exp_valid(ev), .exp_data(ed), .dut_valid(dv), .dut_data(dd),
        .cmp_valid(b_cmp_valid), .mismatch(b_mismatch), .diff(b_diff),
        .err_count(b_err_count), .cmp_count(b_cmp_count), .max_diff(b_max_diff),
        .level(b_level), .overflow(b_overflow), .underflow(b_underflow),
        .busy(b_busy), .finished(b_finished)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle 1=run 2=drain 3=done, FIFO as a queue
    int          m_mode;
    logic [31:0] m_q[$];
    bit          m_cmpv, m_mis0, m_mis2, m_ovf, m_unf;
    logic [31:0] m_diff, m_max;
    longint      m_cmp, m_err0, m_err2;
    int          m_sz;
    logic [31:0] m_e;
    longint      m_abs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_q.delete(); m_cmpv = 0; m_mis0 = 0; m_mis2 = 0;
            m_ovf = 0; m_unf = 0; m_diff = 0; m_max = 0; m_cmp = 0; m_err0 = 0; m_err2 = 0;
        end else begin
            m_cmpv = 0;
            m_sz   = m_q.size();
            if (m_mode == 0 || m_mode == 3) begin
                if (start) begin
                    m_q.delete(); m_ovf = 0; m_unf = 0; m_max = 0;
                    m_cmp = 0; m_err0 = 0; m_err2 = 0; m_mode = 1;
                end
            end else begin
                if (dv) begin
                    if (m_q.size() == 0) begin
                        m_unf = 1;
                    end else begin
                        m_e = m_q.pop_front();
                        m_cmpv = 1;
                        if (m_e == NAR || dd == NAR) begin
                            m_diff = m_e ^ dd;
                            m_mis0 = (m_e != dd);
                            m_mis2 = m_mis0;
                        end else begin
                            m_abs  = longint'(m_e) - longint'(dd);
                            if (m_abs < 0) m_abs = -m_abs;
                            m_diff = 32'(m_abs);
                            m_mis0 = (m_abs > 0);
                            m_mis2 = (m_abs > 2);
                        end
                        if (m_cmp < 64'hFFFF_FFFF) m_cmp++;
                        if (m_mis0 && m_err0 < 64'hFFFF_FFFF) m_err0++;
                        if (m_mis2 && m_err2 < 64'hFFFF_FFFF) m_err2++;
                        if (m_diff > m_max) m_max = m_diff;
                    end
                end
                if (m_mode == 1 && ev) begin
                    if (m_q.size() < 16) m_q.push_back(ed);
                    else m_ovf = 1;
                end
                if (m_mode == 1) begin
                    if (!start) m_mode = 2;
                end else if (start) begin
                    m_mode = 1;
                end else if (m_sz == 0) begin
                    m_mode = 3;
                end
            end
        end
    end

    task automatic cmp_inst(input string p, input logic cv, input logic mis, input logic [31:0] df,
                            input logic [31:0] ec, input logic [31:0] cc, input logic [31:0] mx,
                            input logic [4:0] lv, input logic ov, input logic un, input logic bs,
                            input logic fi, input bit emis, input longint eerr);
        chk({p, "cmp_valid"}, cv, m_cmpv);
        chk({p, "mismatch"}, mis, emis);
        chk({p, "diff"}, df, m_diff);
        chk({p, "err_count"}, ec, eerr);
        chk({p, "cmp_count"}, cc, m_cmp);
        chk({p, "max_diff"}, mx, MAXEN ? m_max : 32'd0);
        chk({p, "level"}, lv, m_q.size());
        chk({p, "overflow"}, ov, m_ovf);
        chk({p, "underflow"}, un, m_unf);
        chk({p, "busy"}, bs, (m_mode == 1 || m_mode == 2));
        chk({p, "finished"}, fi, (m_mode == 3));
    endtask

    always @(negedge clk) begin
        cmp_inst("a_", a_cmp_valid, a_mismatch, a_diff, a_err_count, a_cmp_count, a_max_diff,
                 a_level, a_overflow, a_underflow, a_busy, a_finished, m_mis0, m_err0);
        cmp_inst("b_", b_cmp_valid, b_mismatch, b_diff, b_err_count, b_cmp_count, b_max_diff,
                 b_level, b_overflow, b_underflow, b_busy, b_finished, m_mis2, m_err2);
    end

    task automatic cyc(input bit st, input bit e_v, input logic [31:0] e_d,
                       input bit d_v, input logic [31:0] d_d);
        start = st; ev = e_v; ed = e_d; dv = d_v; dd = d_d;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] base;
        if ($urandom_range(0, 7) == 0) return NAR;
        base = ($urandom_range(0, 1) == 1) ? 32'h4000_0000 : 32'hBFFF_FFF0;
        return base + 32'($urandom_range(0, 6));
    endfunction

    bit rs;

    initial begin
        rst_n = 1'b0; start = 0; ev = 0; dv = 0; ed = '0; dd = '0;
        repeat (2) @(negedge clk);
        chk("rst_level", a_level, 0);
        chk("rst_busy", a_busy, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("idle_finished", a_finished, 0);
        cyc(1, 0, 0, 0, 0);
        chk("enter_run_busy", a_busy, 1);

        // single matching pair
        cyc(1, 1, 32'h4000_0000, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h4000_0000);
        chk("match_cmp_valid", a_cmp_valid, 1);
        chk("match_mismatch", a_mismatch, 0);
        chk("match_diff", a_diff, 0);
        chk("match_cmp_count", a_cmp_count, 1);
        cyc(1, 0, 0, 0, 0);
        chk("strobe_one_cycle", a_cmp_valid, 0);

        // tolerance boundary
        cyc(1, 1, 32'h4000_0005, 0, 0);
        cyc(1, 0, 0, 1, 32'h4000_0002);
        chk("tol_diff", b_diff, 3);
        chk("tol_mismatch", b_mismatch, 1);
        chk("tol_err_count", b_err_count, 1);
        chk("tol_max_diff", b_max_diff, MAXEN ? 32'd3 : 32'd0);

        // NaR handling
        cyc(1, 1, NAR, 0, 0);
        cyc(1, 0, 0, 1, NAR);
        chk("nar_eq_mismatch", b_mismatch, 0);
        chk("nar_eq_diff", b_diff, 0);
        cyc(1, 1, NAR, 0, 0);
        cyc(1, 0, 0, 1, 32'h0);
        chk("nar_ne_mismatch", b_mismatch, 1);
        chk("nar_ne_diff", b_diff, 32'h8000_0000);

        // overflow: 17th push dropped
        for (int i = 0; i < 17; i++) cyc(1, 1, 32'h100 + 32'(i), 0, 0);
        chk("full_level", a_level, 16);
        chk("full_overflow", a_overflow, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 1, 32'h100 + 32'(i));
            chk("fifo_order_diff", a_diff, 0);
        end
        chk("drained_level", a_level, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("done_finished", a_finished, 1);
        cyc(1, 0, 0, 0, 0);
        chk("restart_clears_overflow", a_overflow, 0);
        chk("restart_clears_count", a_cmp_count, 0);

        // push and pop together while full
        for (int i = 0; i < 16; i++) cyc(1, 1, 32'h200 + 32'(i), 0, 0);
        cyc(1, 1, 32'h300, 1, 32'h200);
        chk("full_pushpop_overflow", a_overflow, 0);
        chk("full_pushpop_level", a_level, 16);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 1, 32'h201 + 32'(i));

        // underflow
        cyc(1, 0, 0, 1, 32'h5);
        chk("underflow_set", a_underflow, 1);
        chk("underflow_no_cmp", a_cmp_valid, 0);

        // drain with three entries pending
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h4000_0000 + 32'(i), 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("drain_level", a_level, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 32'h4000_0000 + 32'(i));
            chk("drain_busy", a_busy, 1);
            chk("drain_not_finished", a_finished, 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("drain_done", a_finished, 1);
        cyc(1, 0, 0, 0, 0);
        chk("restart_clears_underflow", a_underflow, 0);

        // randomized traffic
        rs = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) rs = !rs;
            cyc(rs, $urandom_range(0, 1) == 1, rnd_word(), $urandom_range(0, 1) == 1, rnd_word());
        end

        // asynchronous reset mid-run
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 32'h4000_0001, 0, 0);
        cyc(1, 1, 32'h4000_0002, 1, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_level", a_level, 0);
        chk("async_busy", a_busy, 0);
        chk("async_cmp_count", a_cmp_count, 0);
        chk("async_diff", a_diff, 0);
        chk("async_cmp_valid", a_cmp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 32'h1, 1, 32'h1);
        chk("post_reset_idle", a_busy, 0);
        cyc(1, 0, 0, 0, 0);
        chk("post_reset_run_level", a_level, 0);
        cyc(1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/posit_stream_checker.md
POSIT_STREAM_CHECKER -- requirements
Module: posit_stream_checker

Interface
REQ-001 Parameter N, default 32: posit word width in bits.
REQ-002 Parameter DEPTH, default 16: expected-result FIFO depth, power of two, at least 2.
REQ-003 Parameter TOL, default 0: largest unsigned absolute difference still counted as a match.
REQ-004 Port clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port start, input, 1 bit: run window; high means the checker is running.
REQ-007 Port exp_valid and exp_data, inputs, 1 and N bits: golden result push.
REQ-008 Port dut_valid and dut_data, inputs, 1 and N bits: adder result and its done strobe.
REQ-009 Port cmp_valid, output, 1 bit: one-cycle strobe marking a completed comparison.
REQ-010 Port mismatch, output, 1 bit: qualified by cmp_valid.
REQ-011 Port diff, output, N bits: absolute difference of the last comparison.
REQ-012 Port err_count and cmp_count, outputs, 32 bits each: saturating counters.
REQ-013 Port max_diff, output, N bits: largest diff seen in the current run.
REQ-014 Port level, output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-015 Port overflow and underflow, outputs, 1 bit each: sticky error flags.
REQ-016 Port busy and finished, outputs, 1 bit each: FSM status.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE; busy is high in RUN and DRAIN; finished is high only in DONE.
REQ-018 IDLE or DONE to RUN when start is sampled high; this entry clears counters, max_diff, sticky flags and the FIFO.
REQ-019 RUN to DRAIN when start is sampled low.
REQ-020 DRAIN to DONE in the cycle after level reaches 0.
REQ-021 DRAIN back to RUN if start is sampled high, without clearing anything.
REQ-022 exp_valid and dut_valid are ignored in IDLE and DONE; exp_valid is also ignored in DRAIN.
REQ-023 A push with exp_valid=1 while level=DEPTH is dropped and sets overflow, except when a pop occurs in the same cycle.
REQ-024 A pop happens on dut_valid=1 with level>0; FIFO read and write pointers wrap modulo DEPTH.
REQ-025 dut_valid=1 with level=0 sets underflow and discards the sample, including when a push occurs in the same cycle; there is no bypass; the push is still accepted.
REQ-026 Comparison latency is 1 cycle: cmp_valid, diff and mismatch are registered in the cycle after the pop; cmp_valid is low otherwise.
REQ-027 diff is |exp - dut|, computed on both words as unsigned N-bit values.
REQ-028 NaR is 1 followed by N-1 zeros; if either operand is NaR, mismatch = (exp != dut) and diff = (exp XOR dut).
REQ-029 If neither operand is NaR, mismatch = (diff > TOL).
REQ-030 cmp_count increments on every cmp_valid; err_count increments when mismatch is also high; both saturate at 2^32-1.
REQ-031 A simultaneous push and pop leaves level unchanged.

Reset
REQ-032 rst_n low forces, asynchronously, FSM=IDLE, FIFO pointers and level=0, and every output=0.
REQ-033 Reset asserted mid-run discards all FIFO contents and counts; operation resumes only through a new start.

Configuration
REQ-034 With macro POSIT_CHECKER_MAXDIFF_EN defined, max_diff updates to diff when cmp_valid=1 and diff > max_diff, including NaR cases.
REQ-035 Without POSIT_CHECKER_MAXDIFF_EN, max_diff is constant 0 and no comparator or register is built.

Verification
REQ-036 N=32, TOL=0, DEPTH=16: push 0x40000000; 4 cycles later, dut_valid with 0x40000000 -> cmp_valid one cycle later, mismatch=0, diff=0, cmp_count=1.
REQ-037 Expected 0x40000005, dut 0x40000002, TOL=2 -> diff=3, mismatch=1, err_count=1, max_diff=3 (macro on) or 0 (macro off).
REQ-038 Expected 0x80000000 (NaR), dut 0x80000000 -> mismatch=0; dut 0x00000000 instead -> mismatch=1, diff=0x80000000.
REQ-039 17 pushes with no pops -> level=16, overflow=1; the 17th value is never compared; a 17th push with a simultaneous pop -> no overflow.
REQ-040 dut_valid with level=0 -> underflow=1, no cmp_valid; a following start rising edge from DONE clears underflow.
REQ-041 start dropped with level=3, then 3 dut pops -> DRAIN lasts until level=0, finished=1 next cycle; rst_n pulsed low in RUN -> all outputs 0 immediately, without waiting for clk.
